phase_to_sine_converter: RTL and testbench

Consumer end of the DDFS phase path. Takes the registered phase word from the phase accumulator and produces a signed sine amplitude, using a quarter-wave ROM with mirror and negate symmetry. It is a fixed-latency, non-stalling pipeline with a valid qualifier, and it feeds the DAC and output filter.

---
 rtl/ddfs_pkg.sv | 31 +++
 rtl/sine_quarter_rom.sv | 68 ++++++
 rtl/phase_to_sine_converter.sv | 139 +++++++++++++
 tb/tb_phase_to_sine_converter.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ddfs_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ddfs_pkg
// Description : Shared constants and types for the DDFS phase-to-amplitude
//               path (default widths, pipeline depth, dither LFSR settings,
//               quadrant encoding).
// Revision    : 1.0 - initial release
// ============================================================================
package ddfs_pkg;

    localparam int DEF_PHASE_W = 32;
    localparam int DEF_ADDR_W  = 10;
    localparam int DEF_AMP_W   = 16;

    // Number of register stages between phase_in and sine_out
    localparam int PIPE_LAT    = 4;

    // Dither LFSR: x^16 + x^14 + x^13 + x^11 + 1, feedback from bits 15,13,12,10
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    // Quadrant of the sine cycle taken from the two truncated-phase MSBs
    typedef enum logic [1:0] {
        Q0 = 2'd0,
        Q1 = 2'd1,
        Q2 = 2'd2,
        Q3 = 2'd3
    } quadrant_t;

endpackage
`default_nettype wire

// File: rtl/sine_quarter_rom.sv
`default_nettype none
// ============================================================================
// Module      : sine_quarter_rom
// Description : Synchronous quarter-wave sine ROM. Entry i holds
//               round((2^(AMP_W-1)-1) * sin(pi/2 * (i+0.5) / 2^ADDR_W)).
//               The half-LSB offset makes ~addr an exact mirror of addr.
//               The table is computed at elaboration time.
// Revision    : 1.0 - initial release
// ============================================================================
module sine_quarter_rom #(
    parameter int ADDR_W = 10,
    parameter int AMP_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_en,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [AMP_W-2:0]  o_mag
);

    localparam int  c_depth = 1 << ADDR_W;
    localparam real c_pi    = 3.14159265358979323846;

    // Taylor series for sin(x), accurate far below one LSB on [0, pi/2]
    function automatic real f_sin(input real x);
        real term;
        real sum;
        term = x;
        sum  = x;
        for (int k = 1; k < 12; k++) begin
            term = -term * x * x / (real'(2 * k) * real'(2 * k + 1));
            sum  = sum + term;
        end
        return sum;
    endfunction

    // Rounded table entry for index i
    function automatic logic [AMP_W-2:0] f_entry(input int i);
        real amp;
        real x;
        amp = real'((1 << (AMP_W - 1)) - 1);
        x   = (c_pi / 2.0) * (real'(i) + 0.5) / real'(c_depth);
        return (AMP_W-1)'($rtoi(amp * f_sin(x) + 0.5));
    endfunction

    logic [AMP_W-2:0] w_table [0:c_depth-1];
    logic [AMP_W-2:0] r_mag;

    generate
        for (genvar i = 0; i < c_depth; i++) begin : g_tbl
            localparam logic [AMP_W-2:0] c_val = f_entry(i);
            assign w_table[i] = c_val;
        end
    endgenerate

    // Registered table read, loads only when the addressing stage is valid
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mag <= '0;
        end else if (i_en) begin
            r_mag <= w_table[i_addr];
        end
    end

    assign o_mag = r_mag;

endmodule
`default_nettype wire

// File: rtl/phase_to_sine_converter.sv
`default_nettype none
// ============================================================================
// Module      : phase_to_sine_converter
// Description : DDFS phase-to-sine converter. Four-stage non-stalling
//               pipeline: truncate -> quadrant fold -> quarter-wave ROM ->
//               sign. Valid bits shift every cycle; data registers of a
//               stage load only when that stage's incoming valid is set.
//               Optional macro DDFS_PHASE_DITHER_EN adds LFSR phase dither
//               below one ROM step before truncation.
// Revision    : 1.0 - initial release
// ============================================================================
module phase_to_sine_converter
    import ddfs_pkg::*;
#(
    parameter int PHASE_W = DEF_PHASE_W,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int AMP_W   = DEF_AMP_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [PHASE_W-1:0] phase_in,
    input  logic               phase_valid,
    output logic [AMP_W-1:0]   sine_out,
    output logic               out_valid
);

    localparam int c_tw = ADDR_W + 2;

    logic [PHASE_W-1:0]  w_phase;
    logic [c_tw-1:0]     w_trunc;
    logic                w_unused_lsbs;
    logic [PIPE_LAT-1:0] r_vld;
    quadrant_t           r_quad;
    logic [ADDR_W-1:0]   r_idx;
    logic [ADDR_W-1:0]   r_addr;
    logic                r_neg2;
    logic                r_neg3;
    logic [AMP_W-2:0]    w_mag;
    logic [AMP_W-1:0]    r_sine;

`ifdef DDFS_PHASE_DITHER_EN
    // LFSR MSB lands one bit below the truncated-phase LSB
    localparam int c_dith_sh = PHASE_W - ADDR_W - 3 - 15;

    logic [15:0]        r_lfsr;
    logic [PHASE_W-1:0] w_dither;

    // Dither LFSR advances once per accepted phase word
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lfsr <= LFSR_SEED;
        end else if (phase_valid) begin
            r_lfsr <= {r_lfsr[14:0], ^(r_lfsr & LFSR_TAPS)};
        end
    end

    generate
        if (c_dith_sh >= 0) begin : g_dith_shl
            assign w_dither = {{(PHASE_W-16){1'b0}}, r_lfsr} << c_dith_sh;
        end else begin : g_dith_shr
            assign w_dither = {{(PHASE_W-16){1'b0}}, (r_lfsr >> (-c_dith_sh))};
        end
    endgenerate

    assign w_phase = phase_in + w_dither;
`else
    assign w_phase = phase_in;
`endif

    // Discarded LSBs are truncated, never rounded (a carry would hit the quadrant)
    assign w_trunc       = w_phase[PHASE_W-1 -: c_tw];
    assign w_unused_lsbs = ^w_phase[PHASE_W-c_tw-1:0];

    // Valid bits advance every cycle; there is no stall
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vld <= '0;
        end else begin
            r_vld <= {r_vld[PIPE_LAT-2:0], phase_valid};
        end
    end

    // Stage 1: split truncated phase into quadrant and in-quadrant index
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_quad <= Q0;
            r_idx  <= '0;
        end else if (phase_valid) begin
            r_quad <= quadrant_t'(w_trunc[c_tw-1 -: 2]);
            r_idx  <= w_trunc[ADDR_W-1:0];
        end
    end

    // Stage 2: mirror the index in odd quadrants, flag negation in the lower half
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr <= '0;
            r_neg2 <= 1'b0;
        end else if (r_vld[0]) begin
            r_addr <= r_quad[0] ? ~r_idx : r_idx;
            r_neg2 <= r_quad[1];
        end
    end

    // Stage 3: ROM lookup, sign flag travels alongside
    sine_quarter_rom #(
        .ADDR_W (ADDR_W),
        .AMP_W  (AMP_W)
    ) u_rom (
        .clk    (clk),
        .rst    (rst),
        .i_en   (r_vld[1]),
        .i_addr (r_addr),
        .o_mag  (w_mag)
    );

    // Sign flag pipeline register matching the ROM read stage
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_neg3 <= 1'b0;
        end else if (r_vld[1]) begin
            r_neg3 <= r_neg2;
        end
    end

    // Stage 4: apply sign; peak is 2^(AMP_W-1)-1 so negation cannot overflow
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sine <= '0;
        end else if (r_vld[2]) begin
            r_sine <= r_neg3 ? -{1'b0, w_mag} : {1'b0, w_mag};
        end
    end

    assign sine_out  = r_sine;
    assign out_valid = r_vld[PIPE_LAT-1];

endmodule
`default_nettype wire

// File: tb/tb_phase_to_sine_converter.sv
`default_nettype none
// ============================================================================
// Module      : tb_phase_to_sine_converter
// Description : Directed self-checking bench for phase_to_sine_converter.
//               Inputs change 1 time unit after a rising edge; outputs are
//               sampled at the same point, away from the edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_phase_to_sine_converter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] phase_in = 32'h0;
    logic        phase_valid = 1'b0;
    logic [15:0] sine_out;
    logic        out_valid;

    int checks = 0;
    int errors = 0;
    int sweep_out [0:8191];
    int dith_a [0:999];
    int dith_b [0:999];

    phase_to_sine_converter #(
        .PHASE_W (32),
        .ADDR_W  (10),
        .AMP_W   (16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .phase_in    (phase_in),
        .phase_valid (phase_valid),
        .sine_out    (sine_out),
        .out_valid   (out_valid)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int sval();
        return int'($signed(sine_out));
    endfunction

    // Reference amplitude straight from the sine definition
    function automatic int model(input logic [31:0] ph);
        logic [11:0] p;
        logic [9:0]  a;
        real         v;
        int          m;
        p = ph[31:20];
        a = p[10] ? ~p[9:0] : p[9:0];
        v = 32767.0 * $sin(3.14159265358979323846 / 2.0 * (real'(a) + 0.5) / 1024.0);
        m = $rtoi(v + 0.5);
        return p[11] ? -m : m;
    endfunction

    task automatic test_reset();
        repeat (3) tick();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_valid got %b want 0", out_valid);
        end
        checks++;
        if (sine_out !== 16'h0000) begin
            errors++;
            $display("FAIL reset_sine got %h want 0000", sine_out);
        end
        // valid presented while in reset must never emerge
        phase_in    = 32'h4000_0000;
        phase_valid = 1'b1;
        tick();
        rst         = 1'b0;
        phase_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            checks++;
            if (out_valid !== 1'b0) begin
                errors++;
                $display("FAIL reset_release_valid cycle %0d got %b want 0", i, out_valid);
            end
        end
    endtask

    task automatic test_corners();
        logic [31:0] ph  [5] = '{32'h0000_0000, 32'h3FF0_0000, 32'h4000_0000,
                                 32'h8000_0000, 32'hC000_0000};
        int          exp [5] = '{25, 32767, 32767, -25, -32767};
        for (int k = 0; k < 5; k++) begin
            phase_in    = ph[k];
            phase_valid = 1'b1;
            tick();
            phase_valid = 1'b0;
            tick();
            tick();
            checks++;
            if (out_valid !== 1'b0) begin
                errors++;
                $display("FAIL corner_early ph=%h got valid %b want 0", ph[k], out_valid);
            end
            tick();
            checks++;
            if (out_valid !== 1'b1) begin
                errors++;
                $display("FAIL corner_latency ph=%h got valid %b want 1", ph[k], out_valid);
            end
            checks++;
            if (sval() != exp[k]) begin
                errors++;
                $display("FAIL corner_value ph=%h got %0d want %0d", ph[k], sval(), exp[k]);
            end
            tick();
            checks++;
            if (out_valid !== 1'b0) begin
                errors++;
                $display("FAIL corner_pulse ph=%h got valid %b want 0", ph[k], out_valid);
            end
        end
    endtask

    task automatic test_sweep();
        int j;
        for (int i = 0; i < 8195; i++) begin
            if (i < 8192) begin
                phase_in    = 32'(i) << 20;
                phase_valid = 1'b1;
            end else begin
                phase_valid = 1'b0;
            end
            tick();
            if (i >= 3) begin
                j = i - 3;
                sweep_out[j] = sval();
                checks++;
                if (out_valid !== 1'b1) begin
                    errors++;
                    $display("FAIL sweep_valid sample %0d got %b want 1", j, out_valid);
                end
                checks++;
                if (sval() != model(32'(j) << 20)) begin
                    errors++;
                    $display("FAIL sweep_value sample %0d got %0d want %0d",
                             j, sval(), model(32'(j) << 20));
                end
            end
        end
        for (int k = 0; k < 8192 - 2048; k++) begin
            checks++;
            if (sweep_out[k] != -sweep_out[k + 2048]) begin
                errors++;
                $display("FAIL sweep_antisym sample %0d got %0d want %0d",
                         k, sweep_out[k], -sweep_out[k + 2048]);
            end
        end
    endtask

    task automatic test_bubbles();
        logic        pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        logic [31:0] ph  [6] = '{32'h1000_0000, 32'h2000_0000, 32'h3000_0000,
                                 32'h5000_0000, 32'h6000_0000, 32'h9000_0000};
        int          last;
        logic        expv;
        int          j;
        last = 0;
        for (int i = 0; i < 10; i++) begin
            if (i < 6) begin
                phase_in    = ph[i];
                phase_valid = pat[i];
            end else begin
                phase_valid = 1'b0;
            end
            tick();
            if (i >= 3) begin
                j    = i - 3;
                expv = (j < 6) ? pat[j] : 1'b0;
                if (j < 6 && pat[j]) last = model(ph[j]);
                checks++;
                if (out_valid !== expv) begin
                    errors++;
                    $display("FAIL bubble_valid slot %0d got %b want %b", j, out_valid, expv);
                end
                checks++;
                if (sval() != last) begin
                    errors++;
                    $display("FAIL bubble_hold slot %0d got %0d want %0d", j, sval(), last);
                end
            end
        end
    endtask

    task automatic test_midstream_reset();
        for (int i = 0; i < 3; i++) begin
            phase_in    = 32'h0400_0000 + (32'(i) << 28);
            phase_valid = 1'b1;
            tick();
        end
        phase_valid = 1'b0;
        rst = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL midrst_valid got %b want 0", out_valid);
        end
        checks++;
        if (sine_out !== 16'h0000) begin
            errors++;
            $display("FAIL midrst_sine got %h want 0000", sine_out);
        end
        tick();
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            checks++;
            if (out_valid !== 1'b0) begin
                errors++;
                $display("FAIL midrst_flush cycle %0d got %b want 0", i, out_valid);
            end
        end
    endtask

    task automatic test_back_to_back();
        rst = 1'b1;
        tick();
        rst         = 1'b0;
        phase_in    = 32'h4000_0000;
        phase_valid = 1'b1;
        tick();
        phase_valid = 1'b0;
        tick();
        tick();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_early got %b want 0", out_valid);
        end
        tick();
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL b2b_valid got %b want 1", out_valid);
        end
        checks++;
        if (sval() != 32767) begin
            errors++;
            $display("FAIL b2b_value got %0d want 32767", sval());
        end
    endtask

`ifdef DDFS_PHASE_DITHER_EN
    task automatic run_dither(input bit second);
        rst = 1'b1;
        tick();
        rst      = 1'b0;
        phase_in = 32'h0008_0000;
        for (int i = 0; i < 1003; i++) begin
            phase_valid = (i < 1000);
            tick();
            if (i >= 3) begin
                if (second) dith_b[i-3] = sval();
                else        dith_a[i-3] = sval();
                checks++;
                if (out_valid !== 1'b1) begin
                    errors++;
                    $display("FAIL dither_valid sample %0d got %b want 1", i - 3, out_valid);
                end
            end
        end
        phase_valid = 1'b0;
    endtask

    task automatic test_dither();
        int n25;
        int n75;
        n25 = 0;
        n75 = 0;
        run_dither(1'b0);
        run_dither(1'b1);
        for (int k = 0; k < 1000; k++) begin
            if (dith_a[k] == 25) n25++;
            if (dith_a[k] == 75) n75++;
            checks++;
            if (dith_a[k] != 25 && dith_a[k] != 75) begin
                errors++;
                $display("FAIL dither_range sample %0d got %0d want 25 or 75", k, dith_a[k]);
            end
            checks++;
            if (dith_b[k] != dith_a[k]) begin
                errors++;
                $display("FAIL dither_repeat sample %0d got %0d want %0d", k, dith_b[k], dith_a[k]);
            end
        end
        checks++;
        if (n25 == 0 || n75 == 0) begin
            errors++;
            $display("FAIL dither_both got n25=%0d n75=%0d want both nonzero", n25, n75);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_corners();
        test_sweep();
        test_bubbles();
        test_midstream_reset();
        test_back_to_back();
`ifdef DDFS_PHASE_DITHER_EN
        test_dither();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
